// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI data-island scheduler: grant codes, fixed
// packet headers/bodies and the IEC60958 channel-status maps.
package hdmi_pkg;

  typedef enum logic [2:0] {
    GNT_NULL,
    GNT_AUDIO,
    GNT_ACR,
    GNT_AVI,
    GNT_AIF
  } grant_e;

  localparam logic [7:0] PT_AUDIO = 8'h02;
  localparam logic [7:0] PT_ACR   = 8'h01;
  localparam logic [7:0] PT_AVI   = 8'h82;
  localparam logic [7:0] PT_AIF   = 8'h84;

  localparam logic [23:0] ACR_HDR = {16'h0000, PT_ACR};
  localparam logic [55:0] ACR_BCH = 56'h00_18_00_0a_22_01_00;
  localparam logic [23:0] AVI_HDR = {8'h0d, 8'h02, PT_AVI};
  localparam logic [55:0] AVI_BCH = 56'h00_04_00_08_00_63;
  localparam logic [23:0] AIF_HDR = {8'h0a, 8'h01, PT_AIF};
  localparam logic [55:0] AIF_BCH = 56'h00_00_00_00_00_01_70;

  localparam logic [191:0] CS_L = 192'h0202100004;
  localparam logic [191:0] CS_R = 192'h0202200004;
  localparam int           CSB_LAST = 191;

  // Parity bit covers the 16 sample bits plus the channel-status bit.
  function automatic logic [55:0] audio_body(input logic [31:0] smp,
                                             input logic cl, input logic cr);
    logic pl, pr;
    pl = (^smp[15:0]) ^ cl;
    pr = (^smp[31:16]) ^ cr;
    return {pr, cr, 2'b00, pl, cl, 2'b00, smp[31:16], 8'h00, smp[15:0], 8'h00};
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// Synchronous sample FIFO; a write while full is dropped (sticky ovf) unless
// a pop happens in the same cycle. DEPTH must be a power of two.
module audio_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         resetq,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign pop   = rd && !empty;
  assign push  = wr && (!full || pop);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hdmi_island_sched.sv
// Data-island packet scheduler: buffers audio, tracks owed ACR/AVI/AIF packets
// and grants one packet per slot request.
module hdmi_island_sched
  import hdmi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACR_PERIOD = 45,
  parameter int SLOTS      = 3
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        slot_req,
  input  logic [1:0]  slot_idx,
  input  logic        audio_w,
  input  logic [31:0] audio,
  output logic        audio_full,
  output logic        audio_ovf,
  output logic        pkt_valid,
  output logic [23:0] pkt_hdr,
  output logic [55:0] pkt_bch,
  output logic        pkt_dup4
);

  // Handshake: slot_req is a one-cycle request with no back-pressure; the
  // granted packet appears registered on the next edge with pkt_valid=1 and
  // holds until the next request.

  logic [31:0] head;
  logic        fifo_empty;
  logic        pop;
  logic [5:0]  line;
  logic        line_wrap;
  logic        acr_pend, avi_pend, aif_pend;
  logic [7:0]  csb;
  grant_e      grant;
  logic [23:0] hdr_nxt;
  logic [55:0] bch_nxt;
  logic        dup4_nxt;

  assign line_wrap = line_start && (line == 6'(ACR_PERIOD - 1));
  assign pop       = (grant == GNT_AUDIO);

  audio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk    (clk),
    .resetq (resetq),
    .wr     (audio_w),
    .din    (audio),
    .rd     (pop),
    .dout   (head),
    .full   (audio_full),
    .empty  (fifo_empty),
    .ovf    (audio_ovf)
  );

  // Non-final slots favour audio latency; the final slot guarantees
  // control packets can't be starved by a busy audio stream.
  always_comb begin
    grant = GNT_NULL;
    if (slot_req) begin
      if (int'(slot_idx) < SLOTS - 1) begin
        if (!fifo_empty)   grant = GNT_AUDIO;
        else if (acr_pend) grant = GNT_ACR;
        else if (avi_pend) grant = GNT_AVI;
        else if (aif_pend) grant = GNT_AIF;
      end else if (int'(slot_idx) == SLOTS - 1) begin
        if (acr_pend)         grant = GNT_ACR;
        else if (avi_pend)    grant = GNT_AVI;
        else if (aif_pend)    grant = GNT_AIF;
        else if (!fifo_empty) grant = GNT_AUDIO;
      end
    end
  end

  always_comb begin
    hdr_nxt  = '0;
    bch_nxt  = '0;
    dup4_nxt = 1'b0;
    case (grant)
      GNT_AUDIO: begin
        hdr_nxt = {((csb == 8'd0) ? 8'h10 : 8'h00), 8'h01, PT_AUDIO};
        bch_nxt = audio_body(head, CS_L[csb], CS_R[csb]);
      end
      GNT_ACR: begin
        hdr_nxt  = ACR_HDR;
        bch_nxt  = ACR_BCH;
        dup4_nxt = 1'b1;
      end
      GNT_AVI: begin
        hdr_nxt = AVI_HDR;
        bch_nxt = AVI_BCH;
      end
      GNT_AIF: begin
        hdr_nxt = AIF_HDR;
        bch_nxt = AIF_BCH;
      end
      default: ;
    endcase
  end

  // A set in the same cycle as a grant wins, so a new request is never lost.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      line     <= '0;
      acr_pend <= 1'b0;
      avi_pend <= 1'b0;
      aif_pend <= 1'b0;
      csb      <= '0;
    end else begin
      if (line_start) line <= line_wrap ? 6'd0 : line + 6'd1;
      acr_pend <= (acr_pend && (grant != GNT_ACR)) || line_wrap;
      avi_pend <= (avi_pend && (grant != GNT_AVI)) || frame_start;
      aif_pend <= (aif_pend && (grant != GNT_AIF)) || frame_start;
      if (pop) csb <= (csb == 8'(CSB_LAST)) ? 8'd0 : csb + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pkt_valid <= 1'b0;
      pkt_hdr   <= '0;
      pkt_bch   <= '0;
      pkt_dup4  <= 1'b0;
    end else if (slot_req) begin
      pkt_valid <= 1'b1;
      pkt_hdr   <= hdr_nxt;
      pkt_bch   <= bch_nxt;
      pkt_dup4  <= dup4_nxt;
    end
  end

endmodule

// File: tb/tb_hdmi_island_sched.sv
// Bench for hdmi_island_sched: queue-based reference model, expected packets
// pushed on request and checked by an independent output monitor.
module tb_hdmi_island_sched;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 45;
  localparam int NSLOT  = 3;

  localparam int G_NULL = 0;
  localparam int G_AUD  = 1;
  localparam int G_ACR  = 2;
  localparam int G_AVI  = 3;
  localparam int G_AIF  = 4;

  localparam logic [80:0] EXP_ACR = {24'h000001, 56'h00_18_00_0a_22_01_00, 1'b1};
  localparam logic [80:0] EXP_AVI = {24'h0d0282, 56'h00_04_00_08_00_63, 1'b0};
  localparam logic [80:0] EXP_AIF = {24'h0a0184, 56'h00_00_00_00_00_01_70, 1'b0};

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        slot_req = 1'b0;
  logic [1:0]  slot_idx = 2'd0;
  logic        audio_w = 1'b0;
  logic [31:0] audio = '0;
  logic        audio_full;
  logic        audio_ovf;
  logic        pkt_valid;
  logic [23:0] pkt_hdr;
  logic [55:0] pkt_bch;
  logic        pkt_dup4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]  m_fifo[$];
  logic [80:0]  exp_q[$];
  bit           m_acr, m_avi, m_aif, m_ovf;
  int           m_line, m_csb;
  logic [191:0] cs_l = 192'h0202100004;
  logic [191:0] cs_r = 192'h0202200004;
  logic         req_d;

  hdmi_island_sched #(
    .FIFO_DEPTH (DEPTH),
    .ACR_PERIOD (PERIOD),
    .SLOTS      (NSLOT)
  ) dut (
    .clk         (clk),
    .resetq      (resetq),
    .frame_start (frame_start),
    .line_start  (line_start),
    .slot_req    (slot_req),
    .slot_idx    (slot_idx),
    .audio_w     (audio_w),
    .audio       (audio),
    .audio_full  (audio_full),
    .audio_ovf   (audio_ovf),
    .pkt_valid   (pkt_valid),
    .pkt_hdr     (pkt_hdr),
    .pkt_bch     (pkt_bch),
    .pkt_dup4    (pkt_dup4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_acr = 0; m_avi = 0; m_aif = 0; m_ovf = 0;
    m_line = 0; m_csb = 0;
  endtask

  // One clock cycle of stimulus; the model advances by the same cycle.
  task automatic drive_cycle(input bit fs, input bit ls, input bit req, input int idx,
                             input bit w, input logic [31:0] data);
    int g, sz;
    bit popped, cl, cr;
    logic [31:0] smp;
    logic [80:0] e;
    @(negedge clk);
    check("audio_full", audio_full, m_fifo.size() == DEPTH);
    check("audio_ovf", audio_ovf, m_ovf);
    frame_start = fs; line_start = ls; slot_req = req;
    slot_idx = 2'(idx); audio_w = w; audio = data;

    g = G_NULL;
    sz = m_fifo.size();
    if (req) begin
      if (idx < NSLOT - 1) begin
        if (sz > 0) g = G_AUD; else if (m_acr) g = G_ACR;
        else if (m_avi) g = G_AVI; else if (m_aif) g = G_AIF;
      end else if (idx == NSLOT - 1) begin
        if (m_acr) g = G_ACR; else if (m_avi) g = G_AVI;
        else if (m_aif) g = G_AIF; else if (sz > 0) g = G_AUD;
      end
    end
    popped = 0;
    e = '0;
    case (g)
      G_AUD: begin
        smp = m_fifo.pop_front();
        popped = 1;
        cl = cs_l[m_csb];
        cr = cs_r[m_csb];
        e = {((m_csb == 0) ? 8'h10 : 8'h00), 8'h01, 8'h02,
             (^smp[31:16]) ^ cr, cr, 2'b00, (^smp[15:0]) ^ cl, cl, 2'b00,
             smp[31:16], 8'h00, smp[15:0], 8'h00, 1'b0};
        m_csb = (m_csb + 1) % 192;
      end
      G_ACR: begin e = EXP_ACR; m_acr = 0; end
      G_AVI: begin e = EXP_AVI; m_avi = 0; end
      G_AIF: begin e = EXP_AIF; m_aif = 0; end
      default: e = '0;
    endcase
    if (ls) begin
      if (m_line == PERIOD - 1) begin
        m_line = 0;
        m_acr = 1;
      end else begin
        m_line++;
      end
    end
    if (fs) begin
      m_avi = 1;
      m_aif = 1;
    end
    if (w) begin
      if (popped || sz < DEPTH) m_fifo.push_back(data);
      else m_ovf = 1;
    end
    if (req) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, '0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, pkt_valid, 1'b0);
    check({name, "_hdr"}, pkt_hdr, 24'h0);
    check({name, "_bch"}, pkt_bch, 56'h0);
    check({name, "_dup4"}, pkt_dup4, 1'b0);
    check({name, "_full"}, audio_full, 1'b0);
    check({name, "_ovf"}, audio_ovf, 1'b0);
  endtask

  task automatic do_reset();
    idle(1);
    @(negedge clk);
    frame_start = 0; line_start = 0; slot_req = 0; audio_w = 0;
    resetq = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    resetq = 1;
  endtask

  // Monitor: one packet comparison per request that reached a clock edge.
  always @(posedge clk or negedge resetq) begin
    if (!resetq) req_d <= 1'b0;
    else         req_d <= slot_req;
  end

  always @(negedge clk) begin
    if (resetq && req_d) begin
      if (exp_q.size() == 0) begin
        check("pkt_unexpected", {pkt_valid, pkt_hdr, pkt_bch, pkt_dup4}, 82'h0);
      end else begin
        check("pkt", {pkt_valid, pkt_hdr, pkt_bch, pkt_dup4}, {1'b1, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    model_reset();
    resetq = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("por");
    resetq = 1;

    // Null grants right after reset
    for (int s = 0; s < 3; s++) drive_cycle(0, 0, 1, s, 0, '0);

    // Audio in, audio out, then empty
    drive_cycle(0, 0, 0, 0, 1, 32'h2222_1111);
    drive_cycle(0, 0, 1, 0, 0, '0);
    drive_cycle(0, 0, 1, 0, 0, '0);

    // Frame and ACR priority
    drive_cycle(0, 0, 0, 0, 1, 32'h8001_0003);
    drive_cycle(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < PERIOD; i++) drive_cycle(0, 1, 0, 0, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 0, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);

    // frame_start coincident with an AVI grant keeps AVI owed
    drive_cycle(1, 0, 0, 0, 0, '0);
    drive_cycle(1, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);
    drive_cycle(0, 0, 1, 3, 0, '0);

    // Overflow: fifth write dropped, pops return the first four in order
    for (int i = 1; i <= 5; i++) drive_cycle(0, 0, 0, 0, 1, 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, i % 2, 0, '0);
    // Write with pop while full is accepted
    for (int i = 1; i <= 4; i++) drive_cycle(0, 0, 0, 0, 1, 32'hB000_0000 + 32'(i));
    drive_cycle(0, 0, 1, 0, 1, 32'hB000_0005);
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, 0, 0, '0);

    // Reset between request and output edge
    do_reset();
    drive_cycle(1, 0, 0, 0, 1, 32'h1234_5678);
    @(negedge clk);
    slot_req = 1; slot_idx = 2'd0;
    frame_start = 0; audio_w = 0;
    #2 resetq = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_zero_outputs("midreset");
    slot_req = 0;
    resetq = 1;
    drive_cycle(0, 0, 1, 0, 0, '0);
    drive_cycle(0, 0, 1, 2, 0, '0);

    // csb wrap: 193 audio grants from csb 0
    drive_cycle(0, 0, 0, 0, 1, $urandom);
    for (int i = 0; i < 193; i++) drive_cycle(0, 0, 1, 0, (i < 192), $urandom);

    // Randomized traffic from a clean state
    do_reset();
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom);

    idle(3);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
